// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges ID/EX/MEM stall requests, sequences multi-cycle EX ops, issues branch redirect.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int MC_CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic                id_branch_flag,
    input  logic [31:0]         id_branch_target,
    output logic [5:0]          stall,
    output logic                ex_mc_done,
    output logic                flush,
    output logic                pc_redirect,
    output logic [31:0]         redirect_pc,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_flushes,
    output logic [31:0]         perf_mc_ops
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MC_BUSY = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic                mc_long, mc_hold;

    always_comb begin
        mc_long     = ex_mc_cycles >= MC_CNT_W'(2);
        mc_hold     = (state_q == RUN) ? (ex_mc_start && mc_long) : (cnt_q != '0);
        stall       = !rst         ? 6'b000000 :
                      stallreq_mem ? 6'b011111 :
                      mc_hold      ? 6'b001111 :
                      stallreq_id  ? 6'b000111 : 6'b000000;
        // A frozen EX stage cannot retire, so done waits for the MEM stall to clear
        ex_mc_done  = rst && !stallreq_mem &&
                      ((state_q == RUN) ? (ex_mc_start && !mc_long) : (cnt_q == '0));
        flush       = rst && id_branch_flag && !stall[2];
        pc_redirect = flush;
        redirect_pc = rst ? id_branch_target : 32'h0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (!stallreq_mem) begin
            if (state_q == RUN) begin
                if (ex_mc_start && mc_long) begin
                    state_d = MC_BUSY;
                    cnt_d   = ex_mc_cycles - MC_CNT_W'(2);
                end
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - MC_CNT_W'(1);
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_mc_q, perf_mc_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'b0, |stall};
        perf_flush_d = perf_flush_q + {31'b0, flush};
        perf_mc_d    = perf_mc_q + {31'b0, ex_mc_done};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_mc_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_mc_q    <= perf_mc_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
    assign perf_mc_ops       = perf_mc_q;
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_flushes      = 32'h0;
    assign perf_mc_ops       = 32'h0;
`endif
endmodule
